// File: rtl/id_stage.sv
// RV32I decode stage: immediate generation, write-back bypass, load-use stall,
// JAL resolution in ID, and the registered EX bundle with mispredict squash.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_inst,
  input  logic        ex_br_mispred,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic        id_stall,
  output logic        id_target_taken,
  output logic [31:0] id_target,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm
);

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_REG    = 7'b0110011;

  logic        id_valid_q, id_valid_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_inst_q, ex_inst_d;
  logic [31:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [31:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [31:0] ex_imm_q, ex_imm_d;

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] id_imm;
  logic        rs1_used, rs2_used;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        load_use;
  logic        bubble;

  assign opcode = id_inst[6:0];
  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];

  assign imm_i = {{21{id_inst[31]}}, id_inst[30:20]};
  assign imm_s = {{21{id_inst[31]}}, id_inst[30:25], id_inst[11:7]};
  assign imm_b = {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
  assign imm_u = {id_inst[31:12], 12'b0};
  assign imm_j = {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};

  always_comb begin
    id_imm = 32'd0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: id_imm = imm_i;
      OP_STORE:                 id_imm = imm_s;
      OP_BRANCH:                id_imm = imm_b;
      OP_LUI, OP_AUIPC:         id_imm = imm_u;
      OP_JAL:                   id_imm = imm_j;
      default:                  id_imm = 32'd0;
    endcase
  end

  assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (id_rs1 == 5'd0)                    rs1_val = 32'd0;
    else if (wb_we && (wb_rd == id_rs1))   rs1_val = wb_data;
    if (id_rs2 == 5'd0)                    rs2_val = 32'd0;
    else if (wb_we && (wb_rd == id_rs2))   rs2_val = wb_data;
  end

  // The loaded value only exists after MEM, so a dependent in ID must wait one slot.
  assign ex_rd      = ex_inst_q[11:7];
  assign ex_is_load = (ex_inst_q[6:0] == OP_LOAD);
  assign load_use   = ex_valid_q && ex_is_load && (ex_rd != 5'd0) &&
                      ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

  assign id_stall        = id_valid_q && load_use && !ex_br_mispred;
  assign id_target       = id_pc + imm_j;
  assign id_target_taken = id_valid_q && (opcode == OP_JAL) && !ex_br_mispred && !id_stall;

  assign bubble = ex_br_mispred || id_stall || !id_valid_q;

  always_comb begin
    id_valid_d    = 1'b1;
    ex_valid_d    = 1'b0;
    ex_pc_d       = 32'd0;
    ex_inst_d     = NOP_INST;
    ex_rs1_data_d = 32'd0;
    ex_rs2_data_d = 32'd0;
    ex_imm_d      = 32'd0;
    if (!bubble) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      ex_inst_d     = id_inst;
      ex_rs1_data_d = rs1_val;
      ex_rs2_data_d = rs2_val;
      ex_imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q    <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 32'd0;
      ex_inst_q     <= NOP_INST;
      ex_rs1_data_q <= 32'd0;
      ex_rs2_data_q <= 32'd0;
      ex_imm_q      <= 32'd0;
    end else begin
      id_valid_q    <= id_valid_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_inst_q     <= ex_inst_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_inst     = ex_inst_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, multi-cycle hazard,
// mispredict and reset sequences, then random stimulus against a reference model.
module tb_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc, id_inst;
  logic        ex_br_mispred;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_stall, id_target_taken;
  logic [31:0] id_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_inst(id_inst),
    .ex_br_mispred(ex_br_mispred), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_stall(id_stall),
    .id_target_taken(id_target_taken), .id_target(id_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic mp);
    id_pc = pc; id_inst = inst; rf_rs1_data = r1; rf_rs2_data = r2;
    wb_we = we; wb_rd = rd; wb_data = wd; ex_br_mispred = mp;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    if (((v >> (n - 1)) & 32'd1) != 0) return v - (32'd1 << n);
    return v;
  endfunction

  function automatic logic [31:0] jimm(input logic [31:0] i);
    return sext((((i >> 31) & 1) << 20) | (((i >> 12) & 255) << 12) |
                (((i >> 20) & 1) << 11) | (((i >> 21) & 1023) << 1), 21);
  endfunction

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    case (i & 32'h7f)
      32'h03, 32'h13, 32'h67: return sext(i >> 20, 12);
      32'h23: return sext(((i >> 25) << 5) | ((i >> 7) & 31), 12);
      32'h63: return sext((((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
                          (((i >> 25) & 63) << 5) | (((i >> 8) & 15) << 1), 13);
      32'h37, 32'h17: return i & 32'hFFFF_F000;
      32'h6f: return jimm(i);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] operand(input int rs, input logic we, input int rd,
                                          input logic [31:0] wd, input logic [31:0] rf);
    if (rs == 0) return 32'd0;
    if (we && rd == rs) return wd;
    return rf;
  endfunction

  typedef struct {
    logic [31:0] pc, inst, rf1, rf2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        mp;
    logic [4:0]  e_rs1, e_rs2;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_valid;
    logic [31:0] e_rs1d, e_rs2d, e_imm;
  } vec_t;

  vec_t vecs[9];

  logic        m_idv, m_exv;
  logic [31:0] m_pc, m_inst, m_r1, m_r2, m_imm;

  initial begin
    logic [6:0]  ops[11];
    logic [31:0] inst;
    logic [6:0]  op;
    int          rs1, rs2, exrd;
    logic        u1, u2, e_stall, e_taken, mp, bub;

    vecs[0] = '{32'h4000_0010, 32'h0200_00EF, 32'hAA, 32'hBB, 1'b0, 5'd0, 32'h0, 1'b0,
                5'd0, 5'd0, 1'b1, 32'h4000_0030, 1'b1, 32'h0, 32'h0, 32'h20};
    vecs[1] = '{32'h100, 32'h0011_8213, 32'h0, 32'h55, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0,
                5'd3, 5'd1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'h55, 32'h1};
    vecs[2] = '{32'h100, 32'h0011_8213, 32'h1234, 32'h55, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0,
                5'd3, 5'd1, 1'b0, 32'h0, 1'b1, 32'h1234, 32'h55, 32'h1};
    vecs[3] = '{32'h200, 32'hFE71_2E23, 32'h10, 32'h20, 1'b1, 5'd7, 32'hCAFE, 1'b0,
                5'd2, 5'd7, 1'b0, 32'h0, 1'b1, 32'h10, 32'hCAFE, 32'hFFFF_FFFC};
    vecs[4] = '{32'h300, 32'hFE20_8CE3, 32'h7, 32'h9, 1'b0, 5'd1, 32'hEEEE, 1'b0,
                5'd1, 5'd2, 1'b0, 32'h0, 1'b1, 32'h7, 32'h9, 32'hFFFF_FFF8};
    vecs[5] = '{32'h400, 32'h8000_0517, 32'hAAAA, 32'hBBBB, 1'b1, 5'd0, 32'h77, 1'b0,
                5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h8000_0000};
    vecs[6] = '{32'h500, 32'h0072_8333, 32'h11, 32'h22, 1'b1, 5'd5, 32'h99, 1'b0,
                5'd5, 5'd7, 1'b0, 32'h0, 1'b1, 32'h99, 32'h22, 32'h0};
    vecs[7] = '{32'h4, 32'hFF9F_F06F, 32'h31, 32'h25, 1'b0, 5'd0, 32'h0, 1'b0,
                5'd31, 5'd25, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h31, 32'h25, 32'hFFFF_FFF8};
    vecs[8] = '{32'h4000_0010, 32'h0200_00EF, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};

    // reset and release
    rst = 1'b1;
    drive(32'h0, NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ex_inst", ex_inst, NOP);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    rst = 1'b0;
    drive(32'h4000_0010, 32'h0200_00EF, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("first_id_taken", {31'd0, id_target_taken}, 32'd0);
    chk("first_id_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    chk("first_ex_bubble", {31'd0, ex_valid}, 32'd0);
    @(negedge clk); #1;
    chk("second_id_taken", {31'd0, id_target_taken}, 32'd1);
    @(posedge clk); #1;
    chk("second_ex_valid", {31'd0, ex_valid}, 32'd1);

    // directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pc, vecs[i].inst, vecs[i].rf1, vecs[i].rf2,
            vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].mp);
      #1;
      chk($sformatf("v%0d_rs1", i), {27'd0, id_rs1}, {27'd0, vecs[i].e_rs1});
      chk($sformatf("v%0d_rs2", i), {27'd0, id_rs2}, {27'd0, vecs[i].e_rs2});
      chk($sformatf("v%0d_stall", i), {31'd0, id_stall}, 32'd0);
      chk($sformatf("v%0d_taken", i), {31'd0, id_target_taken}, {31'd0, vecs[i].e_taken});
      if (vecs[i].e_taken) chk($sformatf("v%0d_target", i), id_target, vecs[i].e_target);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_ex_pc", i), ex_pc, vecs[i].e_valid ? vecs[i].pc : 32'd0);
      chk($sformatf("v%0d_ex_inst", i), ex_inst, vecs[i].e_valid ? vecs[i].inst : NOP);
      chk($sformatf("v%0d_ex_rs1", i), ex_rs1_data, vecs[i].e_rs1d);
      chk($sformatf("v%0d_ex_rs2", i), ex_rs2_data, vecs[i].e_rs2d);
      chk($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].e_imm);
    end

    // load-use: lw x5 then add x6,x5,x7
    @(negedge clk);
    drive(32'h300, 32'h0001_2283, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(32'h304, 32'h0072_8333, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("lu_stall", {31'd0, id_stall}, 32'd1);
    @(posedge clk); #1;
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_inst", ex_inst, NOP);
    @(negedge clk); #1;
    chk("lu_replay_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    chk("lu_replay_inst", ex_inst, 32'h0072_8333);
    chk("lu_replay_pc", ex_pc, 32'h304);

    // lw x0 followed by a user of x0
    @(negedge clk);
    drive(32'h310, 32'h0001_2003, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(32'h314, 32'h0000_0333, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("lu_x0_stall", {31'd0, id_stall}, 32'd0);
    // lw x5 followed by lui whose rs1 field happens to be 5
    @(negedge clk);
    drive(32'h318, 32'h0001_2283, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(32'h31C, 32'h0002_82B7, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("lu_lui_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    chk("lu_lui_ex_imm", ex_imm, 32'h0002_8000);
    // load-use hazard overridden by mispredict
    @(negedge clk);
    drive(32'h320, 32'h0001_2283, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(32'h324, 32'h0072_8333, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    #1;
    chk("mp_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    chk("mp_ex_valid", {31'd0, ex_valid}, 32'd0);

    // asynchronous reset mid-run
    @(negedge clk);
    drive(32'h600, 32'h0011_8213, 32'h5, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_inst", ex_inst, NOP);
    chk("async_rst_pc", ex_pc, 32'd0);
    chk("async_rst_rs1", ex_rs1_data, 32'd0);
    chk("async_rst_rs2", ex_rs2_data, 32'd0);
    chk("async_rst_imm", ex_imm, 32'd0);

    // random phase, starting from reset
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h03, 7'h00};
    m_idv = 1'b0; m_exv = 1'b0; m_pc = 0; m_inst = NOP; m_r1 = 0; m_r2 = 0; m_imm = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 10)];
      if (op == 7'h00) op = 7'($urandom);
      inst = $urandom;
      inst[6:0]   = op;
      inst[11:7]  = 5'($urandom_range(0, 7));
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      mp = ($urandom_range(0, 9) == 0);
      drive($urandom, inst, $urandom, $urandom, 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, mp);
      #1;
      rs1  = int'((inst >> 15) & 31);
      rs2  = int'((inst >> 20) & 31);
      exrd = int'((m_inst >> 7) & 31);
      u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
      u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
      e_stall = !mp && m_idv && m_exv && ((m_inst & 32'h7f) == 32'h03) && exrd != 0 &&
                ((u1 && exrd == rs1) || (u2 && exrd == rs2));
      e_taken = m_idv && op == 7'h6f && !mp && !e_stall;
      chk("rnd_rs1", {27'd0, id_rs1}, 32'(rs1));
      chk("rnd_rs2", {27'd0, id_rs2}, 32'(rs2));
      chk("rnd_stall", {31'd0, id_stall}, {31'd0, e_stall});
      chk("rnd_taken", {31'd0, id_target_taken}, {31'd0, e_taken});
      chk("rnd_target", id_target, id_pc + jimm(inst));
      chk("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, m_exv});
      chk("rnd_ex_pc", ex_pc, m_pc);
      chk("rnd_ex_inst", ex_inst, m_inst);
      chk("rnd_ex_rs1", ex_rs1_data, m_r1);
      chk("rnd_ex_rs2", ex_rs2_data, m_r2);
      chk("rnd_ex_imm", ex_imm, m_imm);
      bub = mp || e_stall || !m_idv;
      @(posedge clk);
      if (bub) begin
        m_exv = 1'b0; m_pc = 0; m_inst = NOP; m_r1 = 0; m_r2 = 0; m_imm = 0;
      end else begin
        m_exv = 1'b1; m_pc = id_pc; m_inst = inst;
        m_r1 = operand(rs1, wb_we, int'(wb_rd), wb_data, rf_rs1_data);
        m_r2 = operand(rs2, wb_we, int'(wb_rd), wb_data, rf_rs2_data);
        m_imm = model_imm(inst);
      end
      m_idv = 1'b1;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
